// File: rtl/pipe_stage_hs_if.sv
// rtl/pipe_stage_hs_if.sv - upstream/downstream handshake bundle for pipe_stage_hs
interface pipe_stage_hs_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 4
);
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             count;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, count
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, count
    );
endinterface

// File: rtl/pipe_stage_hs.sv
// rtl/pipe_stage_hs.sv - multi-lane pipeline stage register with valid/ready, flush and optional skid entry
module pipe_stage_hs #(
    parameter int          WIDTH     = 32,
    parameter int          LANES     = 4,
    parameter int          SKID      = 1,
    parameter logic [31:0] NOP_VALUE = 32'h0
) (
    input  logic clk,
    input  logic clr,
    input  logic flush,
    pipe_stage_hs_if.slave bus
);
    localparam int               DW       = WIDTH * LANES;
    localparam logic [WIDTH-1:0] NOP_LANE = WIDTH'(NOP_VALUE);

    // Encoding doubles as the occupancy count driven on the count port.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_t;

    occ_t          state_q, state_d;
    logic [DW-1:0] main_q, skid_q;
    logic          in_ready_q;
    logic          ready, accept, emit;
    logic          load_main, load_skid, promote;

    assign ready  = (SKID != 0) ? in_ready_q : ((state_q == S_EMPTY) || bus.out_ready);
    assign accept = bus.in_valid && ready;
    assign emit   = (state_q != S_EMPTY) && bus.out_ready;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (emit) begin
                    state_d = S_EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = S_FULL;
                end
            end
            S_FULL: begin
                if (emit) begin
                    promote = 1'b1;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        // Flush drops everything, including an accept offered this cycle.
        if (flush) begin
            state_d   = S_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            promote   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != S_FULL);
        end
    end

    // Payload registers need no reset: out_data is masked to NOP while empty.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if (load_main) begin
                main_q <= bus.in_data;
            end else if (promote) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = (state_q != S_EMPTY);
    assign bus.out_data  = (state_q != S_EMPTY) ? main_q : {LANES{NOP_LANE}};
    assign bus.count     = state_q;
endmodule

// File: doc/pipe_stage_hs.md
# pipe_stage_hs

Parametrised pipeline stage register for the processor datapath, carrying `LANES` independent `WIDTH`-bit lanes between adjacent stages (e.g. D→X, X→M) with a valid/ready handshake, back-pressure, and a synchronous flush that inserts a bubble. With `SKID=1`, a two-entry skid buffer registers the ready path, so downstream stalls never create a combinational path back to upstream. All lanes move together as one transfer.

## Interface
Parameters:
- `WIDTH`, 32, bits per lane
- `LANES`, 4, number of lanes (≥1)
- `SKID`, 1, 1 = two-entry skid buffer with registered `in_ready`; 0 = single entry with combinational `in_ready`
- `NOP_VALUE`, 32'h0, value driven on every lane when the stage holds no valid entry (truncated/zero-extended to `WIDTH`)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `clr`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous, discards all held entries
- `in_data`  in  LANES*WIDTH  upstream lanes; lane k is bits [k*WIDTH +: WIDTH]
- `in_valid`  in  1  upstream has a transfer
- `in_ready`  out  1  stage can accept
- `out_data`  out  LANES*WIDTH  downstream lanes
- `out_valid`  out  1  `out_data` is a valid transfer
- `out_ready`  in  1  downstream accepts
- `count`  out  2  entries held (0..2; max 1 when `SKID=0`)

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Emit: `out_valid && out_ready` at a rising edge.
- Priority at each edge: `clr` > `flush` > normal handshake.
- `clr`: on the next edge, `out_valid`=0, `count`=0, `in_ready`=1, and all `out_data` lanes = `NOP_VALUE`.
- `flush`: produces the same state as `clr`. An accept offered in the flush cycle is dropped; an emit in the flush cycle still counts for downstream, but the stage does not re-present that entry.
- `SKID=1` entries are main (drives `out_data`) and skid. Per edge:
  - Empty + accept → main.
  - Main only + accept + emit → main replaced.
  - Main only + accept, no emit → skid filled; `count`=2.
  - Full + emit → skid moves to main; `count`=1.
  - `in_ready` is a register equal to `count<2`. No accept is possible when `count`=2.
- `SKID=0`: a single main entry. `in_ready = !out_valid || out_ready` (combinational). Accept + emit in the same cycle → main replaced.
- While `out_valid && !out_ready`, `out_data` holds stable.
- When `out_valid`=0, `out_data` = `NOP_VALUE` on every lane.
- Order is preserved; no entry is duplicated or lost, except by `flush`/`clr`.
- Lanes are opaque: no arithmetic is applied to them. Lane k of the input appears on lane k of the output.

## Timing
- Latency: accept at edge N → `out_valid`=1 with that data after edge N.
- Throughput: one transfer per cycle, sustained while `out_ready`=1, in both modes.
- `SKID=1`: `in_ready` changes only at edges. `in_ready` drops the cycle after the second stalled accept and rises the cycle after an emit from full.
- Reset or flush asserted mid-stream takes effect at that edge. The first new accept can occur on the following edge.
- `count` updates at the same edge as the accept or emit that changes it.

## Test plan
- Reset: hold `clr` for 2 cycles with `in_valid`=1 and `in_data`=all lanes 32'hFFFFFFFF. Required after release: `out_valid`=0, `in_ready`=1, `count`=0, `out_data`=NOP on all lanes. Nothing is accepted during the clr cycles.
- Streaming (`SKID=1`, `out_ready`=1): send 8 transfers, with lane k of transfer i = {i[15:0], k[15:0]}. Required: each appears one cycle after acceptance, in order, with lanes unswapped, and `count` stays ≤1.
- Back-pressure (`SKID=1`): send A, B, C back-to-back, with `out_ready`=0 from the A-accept edge for 3 cycles, then `out_ready`=1. Required: `count`=2 after B; `in_ready`=0 and C is not accepted until an emit; output order is A, B, C; `out_data`=A is stable during the stall.
- Flush: with `count`=2 (entries A, B), assert `flush` alongside `in_valid`=1 carrying D. Required next cycle: `out_valid`=0, `count`=0, `in_ready`=1, NOP on all lanes; D never appears. A new transfer E accepted on the next edge emerges normally.
- Priority: assert `clr` and `flush` together with a pending emit. Required: the result matches reset; `clr` wins.
- `SKID=0`, `LANES`=2, `WIDTH`=8: `out_ready` toggles 1,0,1,0 while `in_valid`=1 continuously with values 8'h11, 8'h22, …. Required: `in_ready` follows `!out_valid || out_ready` in the same cycle, and there is no loss or duplication.
